// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32I load/store unit and the word-organised data memory.
package rv_mem_pkg;

   // RV32I funct3 encodings for loads and stores
   localparam logic [2:0] F3Lb  = 3'b000;
   localparam logic [2:0] F3Lh  = 3'b001;
   localparam logic [2:0] F3Lw  = 3'b010;
   localparam logic [2:0] F3Lbu = 3'b100;
   localparam logic [2:0] F3Lhu = 3'b101;
   localparam logic [2:0] F3Sb  = 3'b000;
   localparam logic [2:0] F3Sh  = 3'b001;
   localparam logic [2:0] F3Sw  = 3'b010;

   // Memory read select codes
   localparam logic [2:0] RSelWord  = 3'd0;
   localparam logic [2:0] RSelHalf  = 3'd1;
   localparam logic [2:0] RSelByte  = 3'd2;
   localparam logic [2:0] RSelUHalf = 3'd3;
   localparam logic [2:0] RSelUByte = 3'd4;

   // Memory write select codes
   localparam logic [1:0] WSelWord = 2'd0;
   localparam logic [1:0] WSelHalf = 2'd1;
   localparam logic [1:0] WSelByte = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StLd0,
      StLd1,
      StSt,
      StResp
   } lsu_state_e;

   // Access size in bytes (1, 2 or 4); 0 marks an unusable size field
   function automatic logic [2:0] access_size(input logic [2:0] funct3);
      logic [2:0] size;
      case (funct3[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         2'b10:   size = 3'd4;
         default: size = 3'd0;
      endcase
      return size;
   endfunction

   function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
      logic ok;
      if (we) begin
         ok = (funct3 == F3Sb) || (funct3 == F3Sh) || (funct3 == F3Sw);
      end else begin
         ok = (funct3 == F3Lb) || (funct3 == F3Lh) || (funct3 == F3Lw) ||
              (funct3 == F3Lbu) || (funct3 == F3Lhu);
      end
      return ok;
   endfunction

   // Write select for a naturally aligned store
   function automatic logic [1:0] store_wsel(input logic [2:0] funct3);
      logic [1:0] wsel;
      case (funct3)
         F3Sb:    wsel = WSelByte;
         F3Sh:    wsel = WSelHalf;
         default: wsel = WSelWord;
      endcase
      return wsel;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and extends a load result from two consecutive memory words.
module lsu_load_align
   import rv_mem_pkg::*;
(
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [31:0] window;

   // Shift the 64-bit pair down to the addressed byte, then extend by access type
   always_comb begin
      window = 32'({hi_i, lo_i} >> {off_i, 3'b000});
      case (funct3_i)
         F3Lb:    result_o = {{24{window[7]}}, window[7:0]};
         F3Lh:    result_o = {{16{window[15]}}, window[15:0]};
         F3Lbu:   result_o = {24'd0, window[7:0]};
         F3Lhu:   result_o = {16'd0, window[15:0]};
         default: result_o = window;
      endcase
   end

endmodule

// File: rtl/lsu_dmem_master.sv
// RV32I load/store initiator for a word-organised data memory; splits misaligned accesses.
module lsu_dmem_master
   import rv_mem_pkg::*;
#(
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_dataw,
   input  logic [31:0] mem_datar,
   output logic        mem_wen,
   output logic [2:0]  mem_rsel,
   output logic [1:0]  mem_wsel
);

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_dataw_q, mem_dataw_d;
   logic [1:0]  mem_wsel_q, mem_wsel_d;

   logic        req_fire;
   logic [2:0]  req_size;
   logic        req_mis;
   logic        req_err;
   logic [2:0]  cur_size;
   logic        cur_mis;
   logic        cur_cross;
   logic [1:0]  bcnt_last;
   logic [1:0]  bcnt_nxt;
   logic [31:0] wdata_shift;
   logic [31:0] hi_sel;
   logic [31:0] lo_sel;
   logic [31:0] load_result;

   // Request and in-flight access classification
   always_comb begin
      req_fire    = req_valid && req_ready;
      req_size    = access_size(req_funct3);
      req_mis     = ((req_size == 3'd2) && req_addr[0]) ||
                    ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
      req_err     = !funct3_legal(req_we, req_funct3) || (req_mis && !SPLIT_MISALIGNED);
      cur_size    = access_size(funct3_q);
      cur_mis     = ((cur_size == 3'd2) && addr_q[0]) ||
                    ((cur_size == 3'd4) && (addr_q[1:0] != 2'b00));
      cur_cross   = ({2'b00, addr_q[1:0]} + {1'b0, cur_size}) > 4'd4;
      bcnt_last   = cur_size[1:0] - 2'd1;
      bcnt_nxt    = bcnt_q + 2'd1;
      wdata_shift = wdata_q >> {bcnt_nxt, 3'b000};
      // The word being read this cycle feeds the aligner directly
      lo_sel      = (state_q == StLd0) ? mem_datar : lo_q;
      hi_sel      = (state_q == StLd1) ? mem_datar : hi_q;
   end

   lsu_load_align u_load_align (
      .hi_i     (hi_sel),
      .lo_i     (lo_sel),
      .off_i    (addr_q[1:0]),
      .funct3_i (funct3_q),
      .result_o (load_result)
   );

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         wdata_q      <= '0;
         funct3_q     <= '0;
         lo_q         <= '0;
         hi_q         <= '0;
         bcnt_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_dataw_q  <= '0;
         mem_wsel_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         funct3_q     <= funct3_d;
         lo_q         <= lo_d;
         hi_q         <= hi_d;
         bcnt_q       <= bcnt_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_addr_q   <= mem_addr_d;
         mem_dataw_q  <= mem_dataw_d;
         mem_wsel_q   <= mem_wsel_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_fire) begin
               if (req_err)     state_d = StResp;
               else if (req_we) state_d = StSt;
               else             state_d = StLd0;
            end
         end
         StLd0:  state_d = cur_cross ? StLd1 : StResp;
         StLd1:  state_d = StResp;
         StSt: begin
            if (!cur_mis || (bcnt_q == bcnt_last)) state_d = StResp;
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next values: memory-side address/data are set up one edge ahead of use
   always_comb begin
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      funct3_d     = funct3_q;
      lo_d         = lo_q;
      hi_d         = hi_q;
      bcnt_d       = bcnt_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_dataw_d  = mem_dataw_q;
      mem_wsel_d   = mem_wsel_q;
      unique case (state_q)
         StIdle: begin
            if (req_fire) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               bcnt_d   = 2'd0;
               if (req_err) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_we) begin
                  mem_addr_d = req_addr;
                  if (req_mis) begin
                     mem_wsel_d  = WSelByte;
                     mem_dataw_d = {24'd0, req_wdata[7:0]};
                  end else begin
                     mem_wsel_d  = store_wsel(req_funct3);
                     mem_dataw_d = req_wdata;
                  end
               end else begin
                  mem_addr_d = {req_addr[31:2], 2'b00};
               end
            end
         end
         StLd0: begin
            lo_d = mem_datar;
            if (cur_cross) begin
               mem_addr_d = {addr_q[31:2] + 30'd1, 2'b00};
            end else begin
               resp_valid_d = 1'b1;
               resp_rdata_d = load_result;
            end
         end
         StLd1: begin
            hi_d         = mem_datar;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_result;
         end
         StSt: begin
            if (cur_mis && (bcnt_q != bcnt_last)) begin
               bcnt_d      = bcnt_nxt;
               mem_addr_d  = addr_q + {30'd0, bcnt_nxt};
               mem_dataw_d = {24'd0, wdata_shift[7:0]};
            end else begin
               resp_valid_d = 1'b1;
            end
         end
         StResp: begin
         end
         default: begin
         end
      endcase
   end

   // Combinational outputs; write enable is gated by reset so no write lands while rst is high
   always_comb begin
      req_ready  = (state_q == StIdle) && !rst;
      mem_wen    = (state_q == StSt) && !rst;
      mem_rsel   = RSelWord;
      resp_valid = resp_valid_q;
      resp_rdata = resp_rdata_q;
      resp_err   = resp_err_q;
      mem_addr   = mem_addr_q;
      mem_dataw  = mem_dataw_q;
      mem_wsel   = mem_wsel_q;
   end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Randomised self-checking bench for lsu_dmem_master against a byte-level reference memory.
module tb_lsu_dmem_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_dataw, mem_datar;
   logic        mem_wen;
   logic [2:0]  mem_rsel;
   logic [1:0]  mem_wsel;

   // Second instance with splitting disabled; its memory always reads zero
   logic        req_valid0, req_ready0, req_we0;
   logic [2:0]  req_funct30;
   logic [31:0] req_addr0, req_wdata0;
   logic        resp_valid0, resp_err0;
   logic [31:0] resp_rdata0;
   logic [31:0] mem_addr0, mem_dataw0;
   logic        mem_wen0;
   logic [2:0]  mem_rsel0;
   logic [1:0]  mem_wsel0;

   lsu_dmem_master #(.SPLIT_MISALIGNED(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_dataw(mem_dataw), .mem_datar(mem_datar),
      .mem_wen(mem_wen), .mem_rsel(mem_rsel), .mem_wsel(mem_wsel)
   );

   lsu_dmem_master #(.SPLIT_MISALIGNED(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_funct3(req_funct30), .req_addr(req_addr0), .req_wdata(req_wdata0),
      .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
      .mem_addr(mem_addr0), .mem_dataw(mem_dataw0), .mem_datar(32'd0),
      .mem_wen(mem_wen0), .mem_rsel(mem_rsel0), .mem_wsel(mem_wsel0)
   );

   // Bench memory: 256 words aliased over the address space
   logic [31:0] mem [256];
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_data;

   assign mem_datar = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_idx] <= pre_data;
      end else if (mem_wen) begin
         case (mem_wsel)
            2'd0: mem[mem_addr[9:2]] <= mem_dataw;
            2'd1: mem[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_dataw[15:0];
            default: mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_dataw[7:0];
         endcase
      end
   end

   // Reference model: flat byte array with the same aliasing
   logic [7:0] ref_mem [1024];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit legal_of(input bit we, input logic [2:0] f3);
      if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      int unsigned sz = size_of(f3);
      logic [31:0] v = 0;
      for (int k = 0; k < sz; k++) begin
         logic [31:0] b = {24'd0, ref_mem[(a + k) & 32'h3FF]};
         v = v | (b << (8 * k));
      end
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      return v;
   endfunction

   // Issue one request to the splitting instance and check it against the model
   task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd);
      int unsigned sz = size_of(f3);
      bit          legal = legal_of(we, f3);
      bit          mis = legal && ((a % sz) != 0);
      bit          exp_err = !legal;
      int          exp_lat, exp_nw, lat, nw, guard;
      bit          got;
      logic [31:0] exp_rd, mask;
      if (exp_err) exp_lat = 1;
      else if (we) exp_lat = mis ? sz + 1 : 2;
      else exp_lat = (((a % 4) + sz) > 4) ? 3 : 2;
      exp_nw = (we && !exp_err) ? (mis ? sz : 1) : 0;
      exp_rd = (!we && !exp_err) ? ref_load(f3, a) : 32'd0;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);

      @(posedge clk);
      #1;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check_eq("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      // Scramble request inputs after acceptance; they must be ignored
      req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 0; nw = 0; got = 0; rd = 0;
      while (!got && lat < 12) begin
         @(negedge clk);
         lat++;
         if (mem_wen) begin
            if (mis) begin
               check_eq("st_byte_addr", mem_addr, a + nw);
               check_eq("st_byte_wsel", {30'd0, mem_wsel}, 32'd2);
               check_eq("st_byte_data", mem_dataw, (wd >> (8 * nw)) & 32'hFF);
            end else begin
               check_eq("st_addr", mem_addr, a);
               check_eq("st_wsel", {30'd0, mem_wsel}, (sz == 4) ? 0 : (sz == 2) ? 1 : 2);
               check_eq("st_data", mem_dataw & mask, wd & mask);
            end
            nw++;
         end
         check_eq("rsel", {29'd0, mem_rsel}, 32'd0);
         if (resp_valid) begin
            got = 1;
            rd = resp_rdata;
            check_eq("resp_rdata", resp_rdata, exp_rd);
            check_eq("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
            check_eq("ready_in_resp", {31'd0, req_ready}, 32'd0);
         end
      end
      check_eq("resp_seen", {31'd0, got}, 32'd1);
      check_eq("latency", lat, exp_lat);
      check_eq("write_count", nw, exp_nw);
      @(negedge clk);
      check_eq("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
      if (we && !exp_err) begin
         for (int k = 0; k < sz; k++) ref_mem[(a + k) & 32'h3FF] = 8'((wd >> (8 * k)) & 32'hFF);
      end
   endtask

   // Load request to the non-splitting instance with explicit expectations
   task automatic do_req0(input logic [2:0] f3, input logic [31:0] a,
                          input bit exp_err, input int exp_lat);
      int  lat;
      bit  got;
      @(posedge clk);
      #1;
      req_valid0 = 1'b1; req_we0 = 1'b0; req_funct30 = f3; req_addr0 = a;
      @(posedge clk);
      #1;
      req_valid0 = 1'b0;
      lat = 0; got = 0;
      while (!got && lat < 12) begin
         @(negedge clk);
         lat++;
         check_eq("ns_no_write", {31'd0, mem_wen0}, 32'd0);
         if (resp_valid0) begin
            got = 1;
            check_eq("ns_err", {31'd0, resp_err0}, {31'd0, exp_err});
            check_eq("ns_rdata", resp_rdata0, 32'd0);
         end
      end
      check_eq("ns_resp_seen", {31'd0, got}, 32'd1);
      check_eq("ns_latency", lat, exp_lat);
   endtask

   logic [31:0] rd;

   initial begin
      rst = 1'b1;
      req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      req_valid0 = 0; req_we0 = 0; req_funct30 = 0; req_addr0 = 0; req_wdata0 = 0;
      pre_we = 1'b1; pre_idx = 0; pre_data = 0;
      for (int i = 0; i < 256; i++) begin
         logic [31:0] w = $urandom;
         pre_idx = 8'(i); pre_data = w;
         for (int k = 0; k < 4; k++) ref_mem[4 * i + k] = w[8 * k +: 8];
         @(posedge clk);
         #1;
      end
      pre_we = 1'b0;
      @(negedge clk);
      check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      check_eq("rst_mem_dataw", mem_dataw, 32'd0);
      check_eq("rst_resp_rdata", resp_rdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_req_ready", {31'd0, req_ready}, 32'd1);

      // Directed cases
      do_req(1, 3'b010, 32'h100, 32'hDEADBEEF, rd);
      do_req(0, 3'b010, 32'h100, 32'h0, rd);
      check_eq("lw_deadbeef", rd, 32'hDEADBEEF);
      do_req(1, 3'b010, 32'h100, 32'h11223344, rd);
      do_req(1, 3'b000, 32'h101, 32'h000000A5, rd);
      do_req(0, 3'b000, 32'h101, 32'h0, rd);
      check_eq("lb_sext", rd, 32'hFFFFFFA5);
      do_req(0, 3'b100, 32'h101, 32'h0, rd);
      check_eq("lbu_zext", rd, 32'h000000A5);
      do_req(0, 3'b010, 32'h100, 32'h0, rd);
      check_eq("lw_after_sb", rd, 32'h1122A544);
      do_req(1, 3'b010, 32'h100, 32'h44332211, rd);
      do_req(1, 3'b010, 32'h104, 32'h88776655, rd);
      do_req(0, 3'b010, 32'h103, 32'h0, rd);
      check_eq("lw_cross", rd, 32'h77665544);
      do_req(1, 3'b001, 32'h107, 32'h0000BEEF, rd);
      do_req(0, 3'b101, 32'h107, 32'h0, rd);
      check_eq("lhu_cross", rd, 32'h0000BEEF);
      do_req(0, 3'b001, 32'h107, 32'h0, rd);
      check_eq("lh_cross", rd, 32'hFFFFBEEF);
      do_req(0, 3'b011, 32'h100, 32'h0, rd);
      do_req(1, 3'b100, 32'h100, 32'h12345678, rd);
      do_req(1, 3'b010, 32'hFFFFFFFC, 32'hAABBCCDD, rd);
      do_req(1, 3'b010, 32'h00000000, 32'h11223344, rd);
      do_req(0, 3'b010, 32'hFFFFFFFE, 32'h0, rd);
      check_eq("lw_wrap", rd, 32'h3344AABB);

      // Reset during the second byte of a misaligned word store
      @(posedge clk);
      #1;
      req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h201;
      req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      req_valid = 0;
      @(negedge clk);
      check_eq("mrst_byte0_wen", {31'd0, mem_wen}, 32'd1);
      check_eq("mrst_byte0_addr", mem_addr, 32'h201);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("mrst_wen_gated", {31'd0, mem_wen}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("mrst_ready_after", {31'd0, req_ready}, 32'd1);
      check_eq("mrst_no_resp", {31'd0, resp_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("mrst_no_resp_later", {31'd0, resp_valid}, 32'd0);
      end
      ref_mem[32'h201] = 8'h0D;
      do_req(0, 3'b100, 32'h201, 32'h0, rd);
      do_req(0, 3'b100, 32'h202, 32'h0, rd);

      // Non-splitting instance
      do_req0(3'b010, 32'h102, 1'b1, 1);
      do_req0(3'b001, 32'h101, 1'b1, 1);
      do_req0(3'b010, 32'h100, 1'b0, 2);
      do_req0(3'b100, 32'h103, 1'b0, 2);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF8 + $urandom_range(0, 7);
         else a = 32'h100 + $urandom_range(0, 255);
         do_req(1'($urandom_range(0, 1)), 3'($urandom), a, $urandom, rd);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
Load/store initiator between the execute stage and the word-organised data memory (32-bit words, byte address, combinational read, write on rising clk, Wen/RSel/WSel select codes). It accepts one RV32I load or store per handshake and drives the memory-side address, data, write enable and select lines. It performs all load byte extraction and sign/zero extension internally. Accesses that are misaligned are split into several aligned memory cycles.

Parameters:
SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into multiple memory cycles; 0 = reject them with resp_err.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid; illegal funct3 or rejected misaligned access
mem_addr  out  32  memory byte address
mem_dataw  out  32  memory write data
mem_datar  in  32  memory read data, combinational from mem_addr
mem_wen  out  1  memory write enable
mem_rsel  out  3  read select; always 0 (word)
mem_wsel  out  2  write select: 0 word, 1 halfword, 2 byte

Behaviour:
- Reset: synchronous, active-high. Takes effect at the next rising edge.
  - State goes to IDLE; request registers clear.
  - Registered outputs go to 0: resp_valid, resp_rdata, resp_err, mem_addr, mem_dataw, mem_wsel.
  - mem_rsel is tied to 0.
  - req_ready = 0 while rst = 1.
  - mem_wen is gated combinationally with !rst, so no write commits in any cycle where rst is high.
- Mid-operation reset: the request is abandoned and no response is issued. A misaligned store may leave earlier bytes already written.
- Request handshake:
  - req_ready = 1 only in IDLE (and rst = 0).
  - On acceptance, addr, wdata, we and funct3 are registered. Inputs are ignored at all other times.
- Definitions: size = 1/2/4 bytes; off = addr[1:0]; misaligned = (addr mod size) != 0; crossing = off + size > 4.
- FSM states: IDLE, LD0, LD1, ST, RESP.
- Transitions out of IDLE on accept:
  - Illegal funct3, or misaligned with SPLIT_MISALIGNED = 0 -> RESP with resp_err = 1.
  - Load -> LD0.
  - Store -> ST.
- LD0: mem_addr = {addr[31:2], 2'b00}, mem_wen = 0. mem_datar is captured into the low buffer. Then LD1 if crossing, else RESP.
- LD1: mem_addr = {addr[31:2] + 1, 2'b00}, wrapping modulo 2^32. mem_datar is captured into the high buffer. Then RESP.
- Load result: ({hi, lo} >> 8*off), truncated to size bytes. Sign-extended for LB/LH, zero-extended for LBU/LHU/LW. Registered into resp_rdata on entry to RESP.
- ST aligned: one cycle, mem_wen = 1, mem_addr = addr.
  - mem_wsel = 0 for SW, 1 for SH, 2 for SB.
  - mem_dataw = wdata, with only the low 16 or 8 bits significant for SH/SB.
- ST misaligned: size consecutive cycles. Byte k (k = 0..size-1):
  - mem_addr = addr + k (mod 2^32), mem_wsel = 2, mem_dataw = {24'b0, wdata[8k+7:8k]}, ascending order.
  - A 2-bit byte counter tracks progress.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. Response fields are held stable only in that cycle.
- Latency from accept edge to resp_valid cycle:
  - aligned or non-crossing load 2; crossing load 3.
  - aligned store 2; misaligned store size + 1.
  - error 1.
- Outside ST, mem_wen = 0. mem_addr/mem_dataw hold their last value.
- Boundary conditions:
  - Address 0xFFFFFFFE with LW: second read wraps to 0x00000000.
  - A new request arriving in RESP is not accepted until IDLE.

Decomposition:
- Package rv_mem_pkg:
  - funct3 load/store constants.
  - RSel codes (0 word, 1 half, 2 byte, 3 uhalf, 4 ubyte) and WSel codes (0 word, 1 half, 2 byte).
  - FSM state enum.
  - size-decode function.
- Sub-module lsu_load_align: combinational {hi, lo}, off, funct3 -> extended 32-bit result.

Test Plan:
- SW 0x100 data 0xDEADBEEF -> one cycle mem_wen = 1, wsel = 0, addr 0x100; resp_valid 2 cycles after accept. Then LW 0x100 -> resp_rdata 0xDEADBEEF, resp_err 0.
- Word 0x11223344 at 0x100; SB 0x101 data 0x000000A5 -> wsel = 2 write. Then LB 0x101 -> 0xFFFFFFA5; LBU 0x101 -> 0x000000A5; LW 0x100 -> 0x1122A544.
- MEM 0x100 = 0x44332211, 0x104 = 0x88776655; LW 0x103 -> reads 0x100 then 0x104; resp_rdata 0x77665544, latency 3.
- SH 0x107 data 0x0000BEEF -> byte writes (0x107, dataw 0xEF), (0x108, dataw 0xBE); resp at 3. Then LHU 0x107 -> 0x0000BEEF; LH 0x107 -> 0xFFFFBEEF.
- Load funct3 011 -> no mem_wen and no read cycles; resp_err = 1, rdata 0, latency 1. With SPLIT_MISALIGNED = 0, LW 0x102 -> resp_err = 1.
- rst pulsed during second byte of misaligned SW 0x201 -> mem_wen low in the reset cycle, no resp_valid, req_ready = 1 on the first cycle after reset deasserts.
